stage_if: RTL and testbench

STAGE_IF -- requirements
Module: stage_if

---
 rtl/stage_if_pkg.sv | 20 ++
 rtl/stage_if.sv | 151 +++++++++++++++
 tb/tb_stage_if.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stage_if_pkg.sv
// Shared definitions for the fetch stage: exception codes and the IF->ID bundle layout.
package stage_if_pkg;

  localparam int EXC_W = 5;

  localparam logic [EXC_W-1:0] EC_NONE = 5'd0;
  localparam logic [EXC_W-1:0] EC_ADEL = 5'd4;

  // Bundle layout, MSB first: {instr[31:0], next_pc[31:0], exc_code[EXC_W-1:0]}
  localparam int IF2ID_WIRE_WIDTH = 32 + 32 + EXC_W;

  function automatic logic [IF2ID_WIRE_WIDTH-1:0] if2id_pack(
    input logic [31:0]      instr,
    input logic [31:0]      next_pc,
    input logic [EXC_W-1:0] exc_code
  );
    return {instr, next_pc, exc_code};
  endfunction

endpackage

// File: rtl/stage_if.sv
// Instruction fetch stage: one outstanding word read, stall hold buffer, delayed branch, flush.
// Define IF_ADDR_EXC_EN to raise an address-error exception on a misaligned fetch address.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          MEM_ADDR_WIDTH = 22
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        clear,
  input  logic [31:0]                 clear_pc,
  input  logic                        branch_en,
  input  logic [31:0]                 branch_dest,
  output logic                        mem_rd,
  output logic [MEM_ADDR_WIDTH-1:0]   mem_addr,
  input  logic                        mem_ready,
  input  logic [31:0]                 mem_data,
  output logic [IF2ID_WIRE_WIDTH-1:0] interstage_if2id
);

`ifdef IF_ADDR_EXC_EN
  localparam logic FAULT_EN = 1'b1;
`else
  localparam logic FAULT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t                    state;
  logic [31:0]               pc;
  logic [31:0]               hold_data;
  logic [31:0]               br_target;
  logic                      br_pending;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;

  logic [31:0] pc_plus4;
  logic [31:0] nxt_raw;
  logic [31:0] nxt;
  logic [31:0] clr_addr;
  logic        outstanding;
  logic        capture;

  function automatic logic misaligned(input logic [31:0] a);
    return FAULT_EN & (|a[1:0]);
  endfunction

  // Without the fault feature the low address bits are simply dropped.
  function automatic logic [31:0] fetch_addr(input logic [31:0] a);
    return {a[31:2], a[1:0] & {2{FAULT_EN}}};
  endfunction

  assign pc_plus4    = pc + 32'd4;
  assign nxt_raw     = branch_en ? branch_dest : (br_pending ? br_target : pc_plus4);
  assign nxt         = fetch_addr(nxt_raw);
  assign clr_addr    = fetch_addr(clear_pc);
  assign outstanding = ((state == S_FETCH) && mem_rd) || (state == S_DISCARD);
  assign capture     = !clear && (state == S_FETCH) && mem_rd && mem_ready && stall;
  assign mem_addr    = addr_q;

  always_ff @(posedge clk) begin
    if (capture)
      hold_data <= mem_data;
    if (branch_en)
      br_target <= branch_dest;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= S_FETCH;
      pc               <= RESET_PC;
      mem_rd           <= 1'b0;
      addr_q           <= RESET_PC[MEM_ADDR_WIDTH+1:2];
      br_pending       <= 1'b0;
      interstage_if2id <= if2id_pack(32'h0, RESET_PC, EC_NONE);
    end else if (clear) begin
      pc               <= clr_addr;
      br_pending       <= 1'b0;
      interstage_if2id <= if2id_pack(32'h0, clear_pc, EC_NONE);
      if (outstanding && !mem_ready) begin
        // The old request stays on the bus untouched until memory answers it.
        state <= S_DISCARD;
      end else begin
        state  <= S_FETCH;
        mem_rd <= !misaligned(clr_addr);
        addr_q <= clr_addr[MEM_ADDR_WIDTH+1:2];
      end
    end else begin
      if (branch_en)
        br_pending <= 1'b1;
      unique case (state)
        S_FETCH: begin
          if (mem_rd) begin
            if (mem_ready && stall) begin
              state  <= S_HOLD;
              mem_rd <= 1'b0;
            end else if (mem_ready) begin
              interstage_if2id <= if2id_pack(mem_data, pc_plus4, EC_NONE);
              pc               <= nxt;
              mem_rd           <= !misaligned(nxt);
              addr_q           <= nxt[MEM_ADDR_WIDTH+1:2];
              br_pending       <= 1'b0;
            end else if (!stall) begin
              // Waiting on memory: present a NOP so ID never consumes a word twice.
              interstage_if2id <= if2id_pack(32'h0, pc, EC_NONE);
            end
          end else if (misaligned(pc)) begin
            if (!stall) begin
              interstage_if2id <= if2id_pack(32'h0, pc_plus4, EC_ADEL);
              state            <= S_HALT;
            end
          end else begin
            mem_rd <= 1'b1;
            addr_q <= pc[MEM_ADDR_WIDTH+1:2];
            if (!stall)
              interstage_if2id <= if2id_pack(32'h0, pc, EC_NONE);
          end
        end
        S_HOLD: begin
          if (!stall) begin
            interstage_if2id <= if2id_pack(hold_data, pc_plus4, EC_NONE);
            state            <= S_FETCH;
            pc               <= nxt;
            mem_rd           <= !misaligned(nxt);
            addr_q           <= nxt[MEM_ADDR_WIDTH+1:2];
            br_pending       <= 1'b0;
          end
        end
        S_DISCARD: begin
          if (!stall)
            interstage_if2id <= if2id_pack(32'h0, pc, EC_NONE);
          if (mem_ready) begin
            state  <= S_FETCH;
            mem_rd <= !misaligned(pc);
            addr_q <= pc[MEM_ADDR_WIDTH+1:2];
          end
        end
        S_HALT: begin
          mem_rd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if: a simple N-wait-state instruction memory plus scenario tasks.
module tb_stage_if;
  import stage_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst, stall, clear, branch_en, mem_rd, mem_ready;
  logic [31:0] clear_pc, branch_dest, mem_data;
  logic [21:0] mem_addr;
  logic [IF2ID_WIRE_WIDTH-1:0] bundle, exp_b;
  int n_cmp = 0;
  int n_fail = 0;
  int waits = 0;
  int cnt;

  always #5 clk = ~clk;

  stage_if dut (
    .clk(clk), .rst(rst), .stall(stall), .clear(clear), .clear_pc(clear_pc),
    .branch_en(branch_en), .branch_dest(branch_dest), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
    .interstage_if2id(bundle)
  );

  function automatic logic [31:0] rom(input logic [21:0] a);
    case (a)
      22'd0:   return 32'h2408_0001;
      22'd1:   return 32'h2409_0002;
      default: return 32'hC000_0000 | {10'b0, a};
    endcase
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) cnt <= 0;
    else if (mem_ready) cnt <= 0;
    else if (mem_rd) cnt <= cnt + 1;

  assign mem_ready = mem_rd && (cnt == waits);
  assign mem_data  = rom(mem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut(input int w);
    stall = 0; clear = 0; branch_en = 0; clear_pc = 0; branch_dest = 0; waits = w;
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    stall = 0; clear = 0; branch_en = 0; clear_pc = 0; branch_dest = 0; waits = 2;
    rst = 1;
    step();
    step();
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_mem_rd: got %b want 0", mem_rd); end
    n_cmp++; if (mem_addr !== 22'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
    exp_b = {32'h0, 32'h0, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL rst_bundle: got %h want %h", bundle, exp_b); end
    rst = 0;
    step();
    n_cmp++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL rst_first_rd: got %b want 1", mem_rd); end
    #2 rst = 1;
    #1;
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL rst_async_abandon: got %b want 0", mem_rd); end
    step();
    rst = 0;
  endtask

  task automatic test_seq();
    reset_dut(0);
    step();
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h0) begin n_fail++; $display("FAIL seq_req0: rd=%b addr=%h want 1/0", mem_rd, mem_addr); end
    step();
    exp_b = {32'h2408_0001, 32'h4, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL seq_b0: got %h want %h", bundle, exp_b); end
    n_cmp++; if (mem_addr !== 22'h1) begin n_fail++; $display("FAIL seq_addr1: got %h want 1", mem_addr); end
    step();
    exp_b = {32'h2409_0002, 32'h8, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL seq_b1: got %h want %h", bundle, exp_b); end
    step();
    exp_b = {32'hC000_0002, 32'hC, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL seq_b2: got %h want %h", bundle, exp_b); end
  endtask

  task automatic test_stall();
    reset_dut(0);
    step();
    step();
    stall = 1;
    exp_b = {32'h2408_0001, 32'h4, EC_NONE};
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL stall_hold%0d: got %h want %h", i, bundle, exp_b); end
      n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL stall_rd_low%0d: got %b want 0", i, mem_rd); end
    end
    stall = 0;
    step();
    exp_b = {32'h2409_0002, 32'h8, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL stall_release: got %h want %h", bundle, exp_b); end
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h2) begin n_fail++; $display("FAIL stall_refetch: rd=%b addr=%h want 1/2", mem_rd, mem_addr); end
    step();
    exp_b = {32'hC000_0002, 32'hC, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL stall_resume: got %h want %h", bundle, exp_b); end
  endtask

  task automatic test_stall_wait();
    reset_dut(1);
    step();
    step();
    step();
    exp_b = {32'h2408_0001, 32'h4, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL sw_b0: got %h want %h", bundle, exp_b); end
    stall = 1;
    step();
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL sw_hold_wait: got %h want %h", bundle, exp_b); end
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h1) begin n_fail++; $display("FAIL sw_req_stable: rd=%b addr=%h want 1/1", mem_rd, mem_addr); end
    step();
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL sw_hold_cap: got %h want %h", bundle, exp_b); end
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL sw_rd_low: got %b want 0", mem_rd); end
    stall = 0;
    step();
    exp_b = {32'h2409_0002, 32'h8, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL sw_release: got %h want %h", bundle, exp_b); end
  endtask

  task automatic test_branch();
    reset_dut(0);
    step();
    step();
    step();
    branch_en = 1; branch_dest = 32'h100;
    step();
    branch_en = 0;
    exp_b = {32'hC000_0002, 32'hC, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL br_delay_slot: got %h want %h", bundle, exp_b); end
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h40) begin n_fail++; $display("FAIL br_target_addr: rd=%b addr=%h want 1/40", mem_rd, mem_addr); end
    step();
    exp_b = {32'hC000_0040, 32'h104, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL br_target_instr: got %h want %h", bundle, exp_b); end
    n_cmp++; if (mem_addr !== 22'h41) begin n_fail++; $display("FAIL br_after_target: got %h want 41", mem_addr); end
    reset_dut(2);
    step();
    branch_en = 1; branch_dest = 32'h200;
    step();
    branch_en = 0;
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h0) begin n_fail++; $display("FAIL brw_req_stable: rd=%b addr=%h want 1/0", mem_rd, mem_addr); end
    step();
    step();
    exp_b = {32'h2408_0001, 32'h4, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL brw_slot: got %h want %h", bundle, exp_b); end
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h80) begin n_fail++; $display("FAIL brw_pending_addr: rd=%b addr=%h want 1/80", mem_rd, mem_addr); end
  endtask

  task automatic test_clear();
    reset_dut(2);
    step();
    clear = 1; clear_pc = 32'h180; branch_en = 1; branch_dest = 32'h300; stall = 1;
    step();
    clear = 0; branch_en = 0; stall = 0;
    exp_b = {32'h0, 32'h180, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL clr_bubble: got %h want %h", bundle, exp_b); end
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h0) begin n_fail++; $display("FAIL clr_keep_req: rd=%b addr=%h want 1/0", mem_rd, mem_addr); end
    step();
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h0) begin n_fail++; $display("FAIL clr_keep_req2: rd=%b addr=%h want 1/0", mem_rd, mem_addr); end
    step();
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h60) begin n_fail++; $display("FAIL clr_new_addr: rd=%b addr=%h want 1/60", mem_rd, mem_addr); end
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL clr_drop_late: got %h want %h", bundle, exp_b); end
    step();
    step();
    step();
    exp_b = {32'hC000_0060, 32'h184, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL clr_first_instr: got %h want %h", bundle, exp_b); end
    n_cmp++; if (mem_addr !== 22'h61) begin n_fail++; $display("FAIL clr_branch_dropped: got %h want 61", mem_addr); end
  endtask

  task automatic test_wrap();
    reset_dut(0);
    clear = 1; clear_pc = 32'hFFFF_FFFC;
    step();
    clear = 0;
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h3F_FFFF) begin n_fail++; $display("FAIL wrap_addr: rd=%b addr=%h want 1/3fffff", mem_rd, mem_addr); end
    step();
    exp_b = {32'hC03F_FFFF, 32'h0, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL wrap_next_pc: got %h want %h", bundle, exp_b); end
    n_cmp++; if (mem_addr !== 22'h0) begin n_fail++; $display("FAIL wrap_addr0: got %h want 0", mem_addr); end
  endtask

  task automatic test_misalign();
    reset_dut(0);
    step();
    branch_en = 1; branch_dest = 32'h102;
    step();
    branch_en = 0;
    exp_b = {32'h2408_0001, 32'h4, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL mis_slot: got %h want %h", bundle, exp_b); end
`ifdef IF_ADDR_EXC_EN
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL mis_no_req: got %b want 0", mem_rd); end
    step();
    exp_b = {32'h0, 32'h106, EC_ADEL};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL mis_adel: got %h want %h", bundle, exp_b); end
    step();
    step();
    n_cmp++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL mis_halt_rd: got %b want 0", mem_rd); end
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL mis_halt_bundle: got %h want %h", bundle, exp_b); end
    clear = 1; clear_pc = 32'h0;
    step();
    clear = 0;
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h0) begin n_fail++; $display("FAIL mis_recover: rd=%b addr=%h want 1/0", mem_rd, mem_addr); end
`else
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 22'h40) begin n_fail++; $display("FAIL mis_forced: rd=%b addr=%h want 1/40", mem_rd, mem_addr); end
    step();
    exp_b = {32'hC000_0040, 32'h104, EC_NONE};
    n_cmp++; if (bundle !== exp_b) begin n_fail++; $display("FAIL mis_forced_instr: got %h want %h", bundle, exp_b); end
`endif
  endtask

  initial begin
    rst = 1; stall = 0; clear = 0; branch_en = 0; clear_pc = 0; branch_dest = 0;
    test_reset();
    test_seq();
    test_stall();
    test_stall_wait();
    test_branch();
    test_clear();
    test_wrap();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
